// File: rtl/grant_burst_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : grant_burst_pkg
//  Purpose : Shared types and default widths for the grant-driven burst
//            controller (FSM state encoding, burst owner encoding).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package grant_burst_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int LEN_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } state_t;

  // OWN_1 is the all-zero encoding so the reset value of the owner register
  // is requester 1.
  typedef enum logic {
    OWN_1 = 1'b0,
    OWN_2 = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/burst_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module  : burst_timeout_ctr
//  Purpose : Counts consecutive stalled cycles of a burst beat and flags the
//            cycle on which the count reaches TIMEOUT. Saturates at TIMEOUT.
//  Ports   : clk      in  clock
//            reset    in  asynchronous active-low reset
//            clear    in  zero the count (beat accepted or bus idle)
//            inc      in  one more stalled cycle
//            expired  out this edge brings the count to TIMEOUT
//  Rev     : 1.0  initial release
// ============================================================================
module burst_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Flag the stall that would take the count to LIMIT so the FSM leaves
  // BURST on exactly the TIMEOUT-th stalled edge.
  assign expired = inc && !clear && (count == (LIMIT - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/grant_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : grant_burst_ctrl
//  Purpose : Runs the burst of whichever requester the upstream round-robin
//            arbiter granted on a single shared memory bus. Latches owner,
//            address, length and direction at grant, issues len+1 beats with
//            a valid/ready handshake, aborts after TIMEOUT stalled cycles and
//            returns a one-cycle done or err pulse to the owner.
//  Ports   : clk, reset(async, active-low)
//            grant_1/2, addr_1/2, len_1/2, we_1/2, wdata_1/2   requester side
//            pop_1/2, done_1/2, err_1/2, busy                  requester side
//            bus_valid, bus_ready, bus_addr, bus_we, bus_wdata,
//            bus_last                                          shared bus
//            proto_err  sticky, both grants seen together in IDLE
//  Rev     : 1.0  initial release
// ============================================================================
module grant_burst_ctrl
  import grant_burst_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              grant_1,
  input  logic              grant_2,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [LEN_W-1:0]  len_1,
  input  logic [LEN_W-1:0]  len_2,
  input  logic              we_1,
  input  logic              we_2,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic [DATA_W-1:0] wdata_2,
  output logic              pop_1,
  output logic              pop_2,
  output logic              done_1,
  output logic              done_2,
  output logic              err_1,
  output logic              err_2,
  output logic              busy,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_last,
  output logic              proto_err
);

  state_t            state;
  owner_t            owner;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat;
  logic              we_q;
  logic              resp_err;
  logic              proto_err_q;

  logic xfer;
  logic last_beat;
  logic tmo_expired;

  assign xfer      = bus_valid && bus_ready;
  assign last_beat = (beat == len_q);

  burst_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!bus_valid || bus_ready),
    .inc     (bus_valid && !bus_ready),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= OWN_1;
      addr_q      <= '0;
      len_q       <= '0;
      beat        <= '0;
      we_q        <= 1'b0;
      resp_err    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Exactly one grant starts a burst; both together is an arbiter
          // protocol violation and is recorded but not serviced.
          if (grant_1 ^ grant_2) begin
            owner    <= grant_1 ? OWN_1 : OWN_2;
            addr_q   <= grant_1 ? addr_1 : addr_2;
            len_q    <= grant_1 ? len_1  : len_2;
            we_q     <= grant_1 ? we_1   : we_2;
            beat     <= '0;
            resp_err <= 1'b0;
            state    <= BURST;
          end
          if (grant_1 && grant_2) begin
            proto_err_q <= 1'b1;
          end
        end
        BURST: begin
          if (xfer) begin
            if (last_beat) begin
              resp_err <= 1'b0;
              state    <= RESP;
            end else begin
              beat <= beat + LEN_W'(1);
            end
          end else if (tmo_expired) begin
            resp_err <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          beat  <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus-side outputs are forced to zero outside BURST so that nothing leaks
  // from the latched registers or the live wdata inputs while idle.
  assign busy      = (state != IDLE);
  assign bus_valid = (state == BURST);
  assign bus_addr  = bus_valid ? (addr_q + ADDR_W'(beat)) : '0;
  assign bus_we    = bus_valid && we_q;
  assign bus_last  = bus_valid && last_beat;
  assign bus_wdata = !bus_valid         ? '0      :
                     (owner == OWN_1)   ? wdata_1 : wdata_2;

  assign pop_1  = xfer && (owner == OWN_1);
  assign pop_2  = xfer && (owner == OWN_2);

  assign done_1 = (state == RESP) && !resp_err && (owner == OWN_1);
  assign done_2 = (state == RESP) && !resp_err && (owner == OWN_2);
  assign err_1  = (state == RESP) &&  resp_err && (owner == OWN_1);
  assign err_2  = (state == RESP) &&  resp_err && (owner == OWN_2);

  assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_grant_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_grant_burst_ctrl
//  Purpose : Self-checking bench for grant_burst_ctrl. Expected beats and
//            responses are queued when a burst is launched and compared by a
//            negedge monitor as the DUT produces them; scenario tasks add
//            their own timing and state checks.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_grant_burst_ctrl;

  logic        clk;
  logic        reset;
  logic        grant_1, grant_2;
  logic [15:0] addr_1, addr_2;
  logic [3:0]  len_1, len_2;
  logic        we_1, we_2;
  logic [31:0] wdata_1, wdata_2;
  logic        pop_1, pop_2, done_1, done_2, err_1, err_2, busy;
  logic        bus_valid, bus_ready, bus_we, bus_last, proto_err;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;

  typedef struct packed {
    logic [15:0] addr;
    logic        last;
    logic        we;
    logic [31:0] wdata;
    logic        p1;
    logic        p2;
  } beat_t;

  beat_t      beat_q[$];
  logic [3:0] resp_q[$];   // {done_1, done_2, err_1, err_2}

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          pop_cnt_1 = 0;
  int          pop_cnt_2 = 0;
  logic [31:0] wbase_1   = 32'h0;
  logic [31:0] wbase_2   = 32'h0;

  // Requester write data advances by one every accepted beat.
  assign wdata_1 = wbase_1 + 32'(pop_cnt_1);
  assign wdata_2 = wbase_2 + 32'(pop_cnt_2);

  grant_burst_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .grant_1   (grant_1),
    .grant_2   (grant_2),
    .addr_1    (addr_1),
    .addr_2    (addr_2),
    .len_1     (len_1),
    .len_2     (len_2),
    .we_1      (we_1),
    .we_2      (we_2),
    .wdata_1   (wdata_1),
    .wdata_2   (wdata_2),
    .pop_1     (pop_1),
    .pop_2     (pop_2),
    .done_1    (done_1),
    .done_2    (done_2),
    .err_1     (err_1),
    .err_2     (err_2),
    .busy      (busy),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_wdata (bus_wdata),
    .bus_last  (bus_last),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: compares every accepted beat and every response
  // pulse against the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (bus_valid && bus_ready) begin
        beat_t got;
        beat_t exp;
        got = '{addr: bus_addr, last: bus_last, we: bus_we, wdata: bus_wdata,
                p1: pop_1, p2: pop_2};
        total_cnt++;
        if (beat_q.size() == 0) begin
          $display("FAIL beat_unexpected: got %h, no beat expected", got);
        end else begin
          exp = beat_q.pop_front();
          if (got !== exp)
            $display("FAIL beat {addr,last,we,wdata,pop1,pop2}: got %h expected %h", got, exp);
          else
            pass_cnt++;
        end
        if (pop_1) pop_cnt_1++;
        if (pop_2) pop_cnt_2++;
      end
      if (done_1 || done_2 || err_1 || err_2) begin
        logic [3:0] got_r;
        logic [3:0] exp_r;
        got_r = {done_1, done_2, err_1, err_2};
        total_cnt++;
        if (resp_q.size() == 0) begin
          $display("FAIL resp_unexpected: got %b, no response expected", got_r);
        end else begin
          exp_r = resp_q.pop_front();
          if (got_r !== exp_r)
            $display("FAIL resp {done1,done2,err1,err2}: got %b expected %b", got_r, exp_r);
          else
            pass_cnt++;
        end
      end
    end
  end

  // Queue the first nb beats of a burst; bus_last is judged against len.
  task automatic push_burst(input bit own2, input logic [15:0] a, input logic [3:0] l,
                            input logic w, input logic [31:0] wb, input int nb);
    for (int k = 0; k < nb; k++) begin
      beat_t b;
      b.addr  = a + 16'(k);
      b.last  = (k == int'(l));
      b.we    = w;
      b.wdata = wb + 32'(own2 ? pop_cnt_2 : pop_cnt_1) + 32'(k);
      b.p1    = !own2;
      b.p2    = own2;
      beat_q.push_back(b);
    end
  endtask

  // Wait (bounded) for any response pulse; n = cycles waited.
  task automatic wait_resp(input int budget, output int n);
    n = 0;
    while (!(done_1 || done_2 || err_1 || err_2) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({pop_1, pop_2, done_1, done_2, err_1, err_2, busy, bus_valid, bus_we,
         bus_last, proto_err, bus_addr, bus_wdata} !== '0)
      $display("FAIL reset_outputs: busy=%b valid=%b addr=%h wdata=%h proto=%b expected all 0",
               busy, bus_valid, bus_addr, bus_wdata, proto_err);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, bus_valid} !== 2'b00)
      $display("FAIL reset_release_idle: busy=%b valid=%b expected 0 0", busy, bus_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic_burst();
    int n;
    wbase_1 = 32'hA100_0000;
    push_burst(1'b0, 16'h0100, 4'd3, 1'b1, wbase_1, 4);
    resp_q.push_back(4'b1000);
    addr_1 = 16'h0100; len_1 = 4'd3; we_1 = 1'b1; bus_ready = 1'b1; grant_1 = 1'b1;
    total_cnt++;
    if (bus_valid !== 1'b0) $display("FAIL basic_idle_valid: got %b expected 0", bus_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    grant_1 = 1'b0;
    // Parameter inputs changing mid-burst must be ignored.
    addr_1 = 16'h5555; len_1 = 4'd0; we_1 = 1'b0;
    total_cnt++;
    if ({bus_valid, busy, bus_addr} !== {2'b11, 16'h0100})
      $display("FAIL basic_first_valid: valid=%b busy=%b addr=%h expected 1 1 0100",
               bus_valid, busy, bus_addr);
    else pass_cnt++;
    wait_resp(40, n);
    total_cnt++;
    if (n != 4) $display("FAIL basic_done_latency: got %0d cycles expected 4", n);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({done_1, busy} !== 2'b00)
      $display("FAIL basic_after_done: done_1=%b busy=%b expected 0 0", done_1, busy);
    else pass_cnt++;
    total_cnt++;
    if (beat_q.size() != 0 || resp_q.size() != 0)
      $display("FAIL basic_drained: beats left %0d resp left %0d expected 0 0",
               beat_q.size(), resp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_stall_single();
    int n;
    wbase_2 = 32'hB200_0000;
    push_burst(1'b1, 16'h0200, 4'd0, 1'b1, wbase_2, 1);
    resp_q.push_back(4'b0100);
    addr_2 = 16'h0200; len_2 = 4'd0; we_2 = 1'b1; bus_ready = 1'b0; grant_2 = 1'b1;
    @(posedge clk); #1;
    grant_2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus_valid, bus_last, pop_2, err_2} !== 4'b1100)
      $display("FAIL stall_hold: valid=%b last=%b pop_2=%b err_2=%b expected 1 1 0 0",
               bus_valid, bus_last, pop_2, err_2);
    else pass_cnt++;
    bus_ready = 1'b1;
    wait_resp(20, n);
    total_cnt++;
    if (n != 1 || {done_2, err_2} !== 2'b10)
      $display("FAIL stall_done: cycles=%0d done_2=%b err_2=%b expected 1 1 0", n, done_2, err_2);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (beat_q.size() != 0 || resp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL stall_drained: beats %0d resp %0d busy %b expected 0 0 0",
               beat_q.size(), resp_q.size(), busy);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    resp_q.push_back(4'b0010);
    addr_1 = 16'h0300; len_1 = 4'd2; we_1 = 1'b0; bus_ready = 1'b0; grant_1 = 1'b1;
    @(posedge clk); #1;
    grant_1 = 1'b0;
    wait_resp(40, n);
    total_cnt++;
    if (n != 15) $display("FAIL timeout_latency: got %0d cycles expected 15", n);
    else pass_cnt++;
    total_cnt++;
    if ({err_1, done_1, bus_valid, busy} !== 4'b1001)
      $display("FAIL timeout_resp: err_1=%b done_1=%b valid=%b busy=%b expected 1 0 0 1",
               err_1, done_1, bus_valid, busy);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, err_1, bus_valid} !== 3'b000 || resp_q.size() != 0)
      $display("FAIL timeout_idle: busy=%b err_1=%b valid=%b resp left %0d expected 0 0 0 0",
               busy, err_1, bus_valid, resp_q.size());
    else pass_cnt++;
    bus_ready = 1'b1;
  endtask

  task automatic test_proto_err();
    int n;
    grant_1 = 1'b1; grant_2 = 1'b1; bus_ready = 1'b1;
    @(posedge clk); #1;
    grant_1 = 1'b0; grant_2 = 1'b0;
    total_cnt++;
    if ({proto_err, bus_valid, busy} !== 3'b100)
      $display("FAIL proto_set: proto=%b valid=%b busy=%b expected 1 0 0", proto_err, bus_valid, busy);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({proto_err, busy} !== 2'b10)
      $display("FAIL proto_sticky: proto=%b busy=%b expected 1 0", proto_err, busy);
    else pass_cnt++;
    wbase_2 = 32'hC400_0000;
    push_burst(1'b1, 16'h0400, 4'd1, 1'b0, wbase_2, 2);
    resp_q.push_back(4'b0100);
    addr_2 = 16'h0400; len_2 = 4'd1; we_2 = 1'b0; grant_2 = 1'b1;
    @(posedge clk); #1;
    grant_2 = 1'b0;
    wait_resp(20, n);
    total_cnt++;
    if (n != 2 || proto_err !== 1'b1)
      $display("FAIL proto_burst: cycles=%0d proto=%b expected 2 1", n, proto_err);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_addr_wrap();
    int n;
    wbase_1 = 32'hD500_0000;
    push_burst(1'b0, 16'hFFFE, 4'd3, 1'b1, wbase_1, 4);
    resp_q.push_back(4'b1000);
    addr_1 = 16'hFFFE; len_1 = 4'd3; we_1 = 1'b1; bus_ready = 1'b1; grant_1 = 1'b1;
    @(posedge clk); #1;
    grant_1 = 1'b0;
    // A foreign grant mid-burst must not change the owner.
    grant_2 = 1'b1;
    @(posedge clk); #1;
    grant_2 = 1'b0;
    wait_resp(20, n);
    total_cnt++;
    if (n != 3 || done_1 !== 1'b1)
      $display("FAIL wrap_done: cycles=%0d done_1=%b expected 3 1", n, done_1);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (beat_q.size() != 0 || busy !== 1'b0)
      $display("FAIL wrap_drained: beats %0d busy %b expected 0 0", beat_q.size(), busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    int n;
    wbase_1 = 32'hE600_0000;
    push_burst(1'b0, 16'h0500, 4'd3, 1'b1, wbase_1, 2);
    addr_1 = 16'h0500; len_1 = 4'd3; we_1 = 1'b1; bus_ready = 1'b1; grant_1 = 1'b1;
    @(posedge clk); #1;
    grant_1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus_addr !== 16'h0502) $display("FAIL midrst_beat2: addr=%h expected 0502", bus_addr);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({pop_1, pop_2, done_1, done_2, err_1, err_2, busy, bus_valid, bus_we,
         bus_last, proto_err, bus_addr, bus_wdata} !== '0)
      $display("FAIL midrst_outputs: busy=%b valid=%b addr=%h wdata=%h proto=%b expected all 0",
               busy, bus_valid, bus_addr, bus_wdata, proto_err);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({done_1, err_1, busy} !== 3'b000 || beat_q.size() != 0)
      $display("FAIL midrst_no_resp: done_1=%b err_1=%b busy=%b beats %0d expected 0 0 0 0",
               done_1, err_1, busy, beat_q.size());
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    wbase_2 = 32'hF700_0000;
    push_burst(1'b1, 16'h0600, 4'd2, 1'b1, wbase_2, 3);
    resp_q.push_back(4'b0100);
    addr_2 = 16'h0600; len_2 = 4'd2; we_2 = 1'b1; grant_2 = 1'b1;
    @(posedge clk); #1;
    grant_2 = 1'b0;
    wait_resp(20, n);
    total_cnt++;
    if (n != 3 || done_2 !== 1'b1)
      $display("FAIL midrst_recover: cycles=%0d done_2=%b expected 3 1", n, done_2);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (beat_q.size() != 0 || resp_q.size() != 0)
      $display("FAIL final_drained: beats %0d resp %0d expected 0 0", beat_q.size(), resp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0;
    grant_1 = 1'b0; grant_2 = 1'b0;
    addr_1 = '0; addr_2 = '0; len_1 = '0; len_2 = '0;
    we_1 = 1'b0; we_2 = 1'b0; bus_ready = 1'b0;
    test_reset();
    test_basic_burst();
    test_stall_single();
    test_timeout();
    test_proto_err();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
